// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access stage: handshake FSM states,
// the W-stage register bundle and the address alignment helper.
package mem_wb_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  typedef struct packed {
    logic             reg_write;
    logic             memto_reg;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  read_data;
    logic [REG_W-1:0] write_reg;
  } wb_bundle_t;

  // Data memory is word addressed on the bus; byte offset bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_handshake.sv
// Data-memory request/acknowledge sequencer: owns the IDLE/BUSY/DONE FSM,
// the request latches that keep the bus stable while waiting, and the
// capture register for load data (valid only in the ack cycle).
module dmem_handshake
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memop_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output ms_state_e         state_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  ms_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  // Next-state logic: latch the access in IDLE, wait for ack in BUSY,
  // spend one DONE cycle handing the result to the W register.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      MS_IDLE: begin
        if (memop_i) begin
          state_d = MS_BUSY;
          req_d   = 1'b1;
          we_d    = we_i;
          addr_d  = ADDR_W'(word_align(addr_i));
          wdata_d = wdata_i;
        end
      end
      MS_BUSY: begin
        // Acks seen in any other state are stray and deliberately ignored.
        if (dmem_ack_i) begin
          state_d = MS_DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : dmem_rdata_i;
        end
      end
      MS_DONE: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and bus latches; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign state_o      = state_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. Memory instructions
// stall the front of the pipe until the data memory acknowledges; the W
// register takes bubbles while stalled and the final result is muxed here.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [4:0]        WriteRegM,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [31:0]       ALUOutW,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       ResultW,
  output logic [4:0]        WriteRegW,
  output logic [CNT_W-1:0]  stall_cycles
);

  ms_state_e       hs_state;
  logic [XLEN-1:0] hs_rdata;
  logic            memop;
  wb_bundle_t      w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign memop = MemtoRegM | MemWriteM;

  dmem_handshake #(
    .ADDR_W (ADDR_W)
  ) u_hs (
    .clk          (clk),
    .rst          (rst),
    .memop_i      (memop),
    .we_i         (MemWriteM),
    .addr_i       (ALUOutM),
    .wdata_i      (WriteDataM),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .state_o      (hs_state),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .rdata_o      (hs_rdata)
  );

  // Stall while a memory op is being launched or is outstanding; never in reset.
  always_comb begin
    StallM = 1'b0;
    if (!rst) begin
      StallM = ((hs_state == MS_IDLE) && memop) || (hs_state == MS_BUSY);
    end
  end

  // W-register next value: bubble while stalled, otherwise the M instruction.
  // A store that also asserts MemtoReg must not select read data in W.
  always_comb begin
    w_d = w_q;
    if (StallM) begin
      w_d.reg_write = 1'b0;
      w_d.memto_reg = 1'b0;
    end else begin
      w_d.reg_write = RegWriteM;
      w_d.memto_reg = MemtoRegM & ~MemWriteM;
      w_d.alu_out   = ALUOutM;
      w_d.write_reg = WriteRegM;
      w_d.read_data = (hs_state == MS_DONE) ? hs_rdata : '0;
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (StallM && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // MEM/WB register and performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign RegWriteW    = w_q.reg_write;
  assign MemtoRegW    = w_q.memto_reg;
  assign ALUOutW      = w_q.alu_out;
  assign ReadDataW    = w_q.read_data;
  assign WriteRegW    = w_q.write_reg;
  assign ResultW      = w_q.memto_reg ? w_q.read_data : w_q.alu_out;
  assign stall_cycles = cnt_q;

endmodule
